// File: rtl/shr_join_pkg.sv
// Shared dataflow constants and width helpers for join-type operators.
// Used by dflow_fifo and shr_join.
package shr_join_pkg;

    localparam int DFLOW_DATA_W     = 16;
    localparam int DFLOW_FIFO_DEPTH = 4;

    // Number of bits needed to index 'value' entries (0 for value <= 1).
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/shr_join_dflow_fifo.sv
// dflow_fifo: synchronous operand FIFO for join-type dataflow operators.
// Push is refused on the pre-edge full flag, so a same-cycle pop never makes room.
module dflow_fifo
    import shr_join_pkg::*;
#(
    parameter int N     = DFLOW_DATA_W,
    parameter int DEPTH = DFLOW_FIFO_DEPTH,
    localparam int PW   = clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic [N-1:0]  push_data,
    input  logic          pop,
    output logic [N-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/shr_join.sv
// shr_join: buffered right-shift join node on the R/D token interface.
// Define SHR_JOIN_ARITH_EN for arithmetic (sign-fill) shift; default is logical.
module shr_join
    import shr_join_pkg::*;
#(
    parameter int N     = DFLOW_DATA_W,
    parameter int DEPTH = DFLOW_FIFO_DEPTH
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         R_IN1,
    input  logic [N-1:0] D_IN1,
    input  logic         R_IN2,
    input  logic [N-1:0] D_IN2,
    output logic         FULL1,
    output logic         FULL2,
    output logic         DROP,
    output logic         R_OUT,
    output logic [N-1:0] D_OUT
);

    localparam int           CW    = clog2(DEPTH) + 1;
    localparam int           SW    = clog2(N);
    localparam logic [N-1:0] N_LIM = N'(N);

    logic [N-1:0]  head1;
    logic [N-1:0]  head2;
    logic [CW-1:0] count1;
    logic [CW-1:0] count2;
    logic          full1;
    logic          full2;
    logic          push1;
    logic          push2;
    logic          join_pop;
    logic          drop_set;
    logic [N-1:0]  shr_result;

    logic          drop_q;
    logic          r_out_q;
    logic [N-1:0]  d_out_q;

    // Amounts of N or more saturate to the fill pattern; the full operand width counts.
    function automatic logic [N-1:0] shift_right(input logic [N-1:0] value,
                                                 input logic [N-1:0] amount);
        logic           fill;
        logic [2*N-1:0] wide;
`ifdef SHR_JOIN_ARITH_EN
        fill = value[N-1];
`else
        fill = 1'b0;
`endif
        if (amount >= N_LIM) begin
            return {N{fill}};
        end
        wide = {{N{fill}}, value} >> amount[SW-1:0];
        return wide[N-1:0];
    endfunction

    assign push1      = EN && R_IN1;
    assign push2      = EN && R_IN2;
    assign join_pop   = EN && (count1 != '0) && (count2 != '0);
    assign drop_set   = EN && ((R_IN1 && full1) || (R_IN2 && full2));
    assign shr_result = shift_right(head1, head2);

    dflow_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_value (
        .clk       (CLK),
        .rst_b     (RST),
        .push      (push1),
        .push_data (D_IN1),
        .pop       (join_pop),
        .head      (head1),
        .count     (count1),
        .full      (full1)
    );

    dflow_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_amount (
        .clk       (CLK),
        .rst_b     (RST),
        .push      (push2),
        .push_data (D_IN2),
        .pop       (join_pop),
        .head      (head2),
        .count     (count2),
        .full      (full2)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            drop_q  <= 1'b0;
            r_out_q <= 1'b0;
            d_out_q <= '0;
        end else if (EN) begin
            if (drop_set) begin
                drop_q <= 1'b1;
            end
            r_out_q <= join_pop;
            if (join_pop) begin
                d_out_q <= shr_result;
            end
        end
    end

    assign FULL1 = full1;
    assign FULL2 = full2;
    assign DROP  = drop_q;
    assign R_OUT = r_out_q;
    assign D_OUT = d_out_q;

endmodule

// File: doc/shr_join.md
Name: shr_join

Overview:
- Dataflow right-shift operator: the complementary operator to the existing left-shift node, on the same R/D token interface.
- Unlike the left-shift node, it does not drop a token when R_IN1 and R_IN2 arrive in different cycles. Each operand stream is buffered in a small FIFO.
- Pairs are joined in arrival order; one registered result token is emitted per pair.
- Sits between producer nodes and any downstream R/D consumer in the dataflow graph.

Parameters:
- N, 16, data width of operands and result.
- DEPTH, 4, entries per operand FIFO; power of 2, min 2.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-low reset.
- EN  input  1  global enable; when low, all state frozen.
- R_IN1  input  1  valid strobe for value operand.
- D_IN1  input  N  value to shift.
- R_IN2  input  1  valid strobe for shift-amount operand.
- D_IN2  input  N  shift amount, unsigned, full width.
- FULL1  output  1  operand-1 FIFO full; producer must not strobe R_IN1.
- FULL2  output  1  operand-2 FIFO full.
- DROP  output  1  sticky: a token was strobed while its FIFO was full.
- R_OUT  output  1  result valid.
- D_OUT  output  N  result.

Behaviour:
- Reset (RST==0 at an edge):
  - Both FIFOs emptied; pointers and counts set to 0.
  - R_OUT=0, D_OUT=0, DROP=0, FULL1=0, FULL2=0.
  - Reset mid-operation discards all buffered tokens; no result is emitted for them.
- EN==0:
  - No push, no pop, no flag update.
  - R_OUT and D_OUT hold their previous values, matching the existing operators' hold semantics.
- Push, per FIFO x, when EN:
  - If R_INx is high and countx<DEPTH, D_INx is written and countx increments.
  - If R_INx is high and countx==DEPTH, the token is discarded and DROP is set. DROP stays set until reset.
- Full flags:
  - FULLx is combinational from the registered count (countx==DEPTH).
  - A pop in the same cycle does not unblock a push in that cycle. Full is evaluated on the pre-edge count.
- Join/pop, when EN:
  - If both counts are >0 at the edge, both heads are popped and D_OUT is loaded with head1 >> head2. R_OUT is set to 1.
  - Otherwise R_OUT is set to 0 and D_OUT holds.
- Simultaneous push and pop on the same FIFO: count unchanged. The pushed data goes behind the popped head.
- Latency:
  - A token written at edge t is poppable at edge t+1.
  - If both operands are strobed in the same cycle into empty FIFOs, R_OUT=1 after edge t+1, i.e. 2 cycles from strobe.
- Throughput: 1 result per cycle while both FIFOs are non-empty.
- Arithmetic:
  - Logical shift; the shift amount is the full N-bit D_IN2.
  - If amount >= N, result is 0.
  - No truncation of D_IN2 to log2(N) bits.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro SHR_JOIN_ARITH_EN.
- Defined: arithmetic shift. Vacated bits are filled with head1[N-1]. For amount >= N, the result is N copies of head1[N-1].
- Undefined: logical shift as above; zero fill.

Decomposition:
- Shared package/include holds the dataflow constants:
  - default data width (16);
  - default FIFO depth (4);
  - clog2 helper function for pointer widths.
- One sub-module, dflow_fifo:
  - parameterised N/DEPTH synchronous FIFO with push/pop/count/full/empty;
  - reused for both operands and by future join-type operators (SHL replacement, ADD, etc.).
- Shift and join logic stay in shr_join.

Test Plan:
- Reset, then R_IN1/R_IN2 strobed together with D_IN1=16'hF000, D_IN2=4 -> R_OUT=1 two cycles later, D_OUT=16'h0F00; R_OUT=0 the next cycle.
- Skewed arrival: R_IN1 strobed with D_IN1=16'h8000, then R_IN2 strobed 3 cycles later with D_IN2=15 -> exactly one result, D_OUT=16'h0001, 2 cycles after the R_IN2 strobe.
  - With SHR_JOIN_ARITH_EN defined the same stimulus gives 16'hFFFF.
- Overflow: 5 R_IN1 tokens with R_IN2 idle (DEPTH=4) -> FULL1=1 after the 4th; 5th discarded; DROP=1. Then 4 R_IN2 tokens of value 1 -> 4 results, in order, from the first 4 values.
- Large shift: D_IN1=16'h1234, D_IN2=16'h0100 -> D_OUT=16'h0000, not a shift by 0.
- EN low for 5 cycles mid-stream with tokens buffered -> no pushes accepted, R_OUT/D_OUT frozen. Streaming resumes in order when EN returns high.
- RST low for one cycle with 3 pairs buffered -> R_OUT=0, FULLx=0, DROP=0; no stale results after release.
